// File: rtl/uart_frame_tx.sv
// Buffered UART transmitter: a small byte FIFO feeding an 8N1 / 8E1 / 8O1 serialiser.
// Bit timing comes from a baud counter on the system clock; tx is registered and idles high.
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int                 PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]     FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic               ODD_SEL  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_d;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift;
  logic             par_bit;
  logic             tx_d, push, pop, shift_adv, bit_end, fifo_empty;

  assign data_ready = (fifo_count != FULL_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign push       = data_valid && data_ready;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign bit_end    = (baud_cnt == CNT_LAST);

  always_comb begin
    state_d    = state;
    tx_d       = tx;
    baud_cnt_d = bit_end ? '0 : baud_cnt + 1'b1;
    bit_idx_d  = bit_idx;
    pop        = 1'b0;
    shift_adv  = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d      = shift[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_bit;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            // shift[1] becomes shift[0] on this same edge
            shift_adv = 1'b1;
            tx_d      = shift[1];
            bit_idx_d = bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          // a queued byte starts immediately, with no idle gap after the stop bit
          if (!fifo_empty) begin
            pop     = 1'b1;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state    <= state_d;
      tx       <= tx_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; control above decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in;
    if (pop) begin
      shift   <= fifo_mem[rd_ptr];
      par_bit <= (^fifo_mem[rd_ptr]) ^ ODD_SEL;
    end else if (shift_adv) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

endmodule
